crack_sched: RTL and testbench
==============================

# crack_sched

Parametrised key-search scheduler for the RC4 cracking datapath. It sweeps a runtime-configured inclusive key range and dispatches candidates to `NUM_LANES` external per-key decrypt/check engines. It stops at the first success and reports the winning key. It generalises the single-engine `crack` flow to N parallel lanes, configurable key width and an arbitrary key sub-range, so several schedulers can split one key space.

## Interface

Parameters:
- `KEY_W`, 24, candidate key width in bits.
- `NUM_LANES`, 2, number of decrypt engines driven (1..8).

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: start request, accepted only while `rdy`=1.
- `rdy` out 1: scheduler idle, or finished and able to accept `en`.
- `key_lo` in `KEY_W`: first candidate, sampled with accepted `en`.
- `key_hi` in `KEY_W`: last candidate, inclusive, sampled with accepted `en`.
- `key` out `KEY_W`: winning key; valid while `key_valid`=1.
- `key_valid` out 1: search ended with a success.
- `done` out 1: search ended, either found or exhausted.
- `lane_en` out `NUM_LANES`: one-cycle start pulse per lane.
- `lane_key` out `NUM_LANES*KEY_W`: key for lane i at `[i*KEY_W +: KEY_W]`. Held stable while lane i is busy.
- `lane_rdy` in `NUM_LANES`: lane i can accept a start.
- `lane_done` in `NUM_LANES`: one-cycle result pulse from lane i.
- `lane_ok` in `NUM_LANES`: qualified by `lane_done[i]`; 1 means all decrypted bytes are printable.
- `lane_abort` out 1: one-cycle pulse telling all lanes to drop work.

## Operation

- States: IDLE, RUN, FINISH.
- IDLE: `rdy`=1. Accepted `en` loads `next_key` ← `key_lo` and `hi` ← `key_hi`, then moves to RUN.
- `next_key` is `KEY_W+1` bits wide, so incrementing past all-ones never wraps to 0. Exhausted means `next_key > hi`.
- Lane busy flag:
  - Set by `lane_en[i]`.
  - Cleared by `lane_done[i]`.
  - A `lane_done` pulse from a non-busy lane is ignored.
- RUN dispatch:
  - At most one dispatch per cycle.
  - Target is the lowest-index lane with `lane_rdy[i]`=1 and not busy, while not exhausted.
  - Dispatch drives `lane_key[i]` ← `next_key`, pulses `lane_en[i]`, and increments `next_key`.
- RUN success:
  - Any `lane_done[i]&lane_ok[i]` on a busy lane is a success. If several succeed in one cycle, the lowest lane index wins.
  - Next cycle: `key` ← that lane's key; `key_valid`=1, `done`=1, `lane_abort` pulses; all busy flags clear; go to FINISH.
  - A dispatch in the same cycle as a success is suppressed.
- RUN exhaustion: exhausted and no lane busy (and no success) → FINISH with `done`=1, `key_valid`=0, `key`=0.
- `key_lo > key_hi`: exhausted at entry. Zero dispatches; FINISH on the next cycle.
- FINISH:
  - `rdy`=1; `done`, `key_valid` and `key` are held.
  - Accepted `en` clears `done`/`key_valid`, reloads the range and enters RUN.
- `en` while in RUN is ignored.

## Timing

- Reset values: `rdy`=1, `key_valid`=0, `done`=0, `key`=0, `lane_en`=0, `lane_key`=0, `lane_abort`=0. State is IDLE and all busy flags are clear.
- `rst` asserted mid-search: all outputs take reset values the following cycle. No `lane_abort` pulse; lanes share `rst`.
- `en` accepted at edge 0: `rdy`=0 from cycle 1. Earliest `lane_en` is cycle 1, with all outputs registered.
- Back-to-back dispatch: with all lanes ready, lanes 0..N-1 start on consecutive cycles.
- A lane is re-dispatchable the cycle after its `lane_done`, if `lane_rdy` is high.
- Success `lane_done` at cycle t: `key_valid`, `done`, `rdy` and `lane_abort` are 1 at cycle t+1.
- Exhaustion: `done` rises 1 cycle after the last busy lane's `lane_done`.

## Test plan

1. `NUM_LANES`=2 with 10-cycle lane models; ok only for key 0x000012; range 0..0xFFFFFF → `key`=0x000012, `key_valid`=1, `done`=1, exactly one `lane_abort` pulse, and no `lane_en` after `done`.
2. Range 5..9 with no ok → exactly 5 `lane_en` pulses carrying keys 5,6,7,8,9 in order. Then `done`=1, `key_valid`=0, `key`=0.
3. Range 0xFFFFFF..0xFFFFFF with ok on that key → a single dispatch and `key`=0xFFFFFF. Key 0 is never dispatched (no wrap).
4. Range 10..3 → `done`=1, `key_valid`=0 within 2 cycles of `en`, with zero `lane_en` pulses.
5. Lane 1 on key 6 and lane 0 on key 7 both return `lane_done`+`lane_ok` in the same cycle → reported `key`=7 (lane 0 wins).
6. `rst` pulsed during RUN → next cycle shows reset values. Re-`en` with range 0..0x20 then finds 0x12, with `key_valid` high one cycle after the ok.

Source files
------------

// File: rtl/crack_sched.sv
// Key-range scheduler: sweeps an inclusive key range over NUM_LANES external
// decrypt engines and reports the first key whose plaintext checks out.
module crack_sched #(
   parameter int KEY_W     = 24,
   parameter int NUM_LANES = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   output logic                       rdy,
   input  logic [KEY_W-1:0]           key_lo,
   input  logic [KEY_W-1:0]           key_hi,
   output logic [KEY_W-1:0]           key,
   output logic                       key_valid,
   output logic                       done,
   output logic [NUM_LANES-1:0]       lane_en,
   output logic [NUM_LANES*KEY_W-1:0] lane_key,
   input  logic [NUM_LANES-1:0]       lane_rdy,
   input  logic [NUM_LANES-1:0]       lane_done,
   input  logic [NUM_LANES-1:0]       lane_ok,
   output logic                       lane_abort
);

   localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   state_t               state;
   logic [KEY_W:0]       next_key;   // extra MSB so stepping past all-ones cannot wrap
   logic [KEY_W:0]       hi;
   logic [NUM_LANES-1:0] busy;
   logic [KEY_W-1:0]     lane_key_q [NUM_LANES];

   logic                 accept;
   logic                 exhausted;
   logic                 success;
   logic                 can_disp;
   logic [KEY_W:0]       cur_key;
   logic [KEY_W:0]       cur_hi;
   logic [NUM_LANES-1:0] free;
   logic [NUM_LANES-1:0] hit;
   logic [NUM_LANES-1:0] busy_left;
   logic [IDX_W-1:0]     win_idx;
   logic [IDX_W-1:0]     disp_idx;

   // On the accepting edge the range comes straight from the ports, which lets
   // the first candidate go out in the cycle right after en.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      win_idx   = '0;
      disp_idx  = '0;
      accept    = en && (state != RUN);
      cur_key   = accept ? {1'b0, key_lo} : next_key;
      cur_hi    = accept ? {1'b0, key_hi} : hi;
      exhausted = cur_key > cur_hi;
      free      = lane_rdy & ~busy;
      hit       = lane_done & lane_ok & busy;
      busy_left = busy & ~lane_done;
      success   = (state == RUN) && (hit != '0);
      // Walk downwards so the lowest index is the one left standing.
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
         if (hit[i])  win_idx  = IDX_W'(i);
         if (free[i]) disp_idx = IDX_W'(i);
      end
      can_disp  = (accept || ((state == RUN) && !success)) && !exhausted && (free != '0);
   end

   genvar g;
   generate
      for (g = 0; g < NUM_LANES; g++) begin : g_lane_key
         assign lane_key[g*KEY_W +: KEY_W] = lane_key_q[g];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         rdy        <= 1'b1;
         key        <= '0;
         key_valid  <= 1'b0;
         done       <= 1'b0;
         lane_en    <= '0;
         lane_abort <= 1'b0;
         busy       <= '0;
         next_key   <= '0;
         hi         <= '0;
         // NOTE: this small key store drives an output port, so it is reset like any flop.
         for (int i = 0; i < NUM_LANES; i++) lane_key_q[i] <= '0;
      end else begin
         // NOTE: non-blocking everywhere here; later assignments deliberately override earlier defaults.
         lane_en    <= '0;
         lane_abort <= 1'b0;
         busy       <= busy_left;

         case (state)
            IDLE, FINISH: begin
               if (en) begin
                  state     <= RUN;
                  rdy       <= 1'b0;
                  done      <= 1'b0;
                  key_valid <= 1'b0;
                  key       <= '0;
                  hi        <= {1'b0, key_hi};
                  next_key  <= {1'b0, key_lo};
               end
            end
            RUN: begin
               if (success) begin
                  state      <= FINISH;
                  key        <= lane_key_q[win_idx];
                  key_valid  <= 1'b1;
                  done       <= 1'b1;
                  rdy        <= 1'b1;
                  lane_abort <= 1'b1;
                  busy       <= '0;
               end else if (exhausted && (busy_left == '0)) begin
                  state     <= FINISH;
                  key       <= '0;
                  key_valid <= 1'b0;
                  done      <= 1'b1;
                  rdy       <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase

         if (can_disp) begin
            lane_en[disp_idx]    <= 1'b1;
            lane_key_q[disp_idx] <= cur_key[KEY_W-1:0];
            busy[disp_idx]       <= 1'b1;
            next_key             <= cur_key + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_crack_sched.sv
// Scoreboard bench for crack_sched: behavioural lane engines with per-key
// latency and a printable-check table, plus a dispatch monitor.
module tb_crack_sched;

   localparam int KEY_W     = 24;
   localparam int NUM_LANES = 2;
   localparam int DEF_LAT   = 10;

   logic                       clk = 1'b0;
   logic                       rst = 1'b1;
   logic                       en = 1'b0;
   logic                       rdy;
   logic [KEY_W-1:0]           key_lo = '0;
   logic [KEY_W-1:0]           key_hi = '0;
   logic [KEY_W-1:0]           key;
   logic                       key_valid;
   logic                       done;
   logic [NUM_LANES-1:0]       lane_en;
   logic [NUM_LANES*KEY_W-1:0] lane_key;
   logic [NUM_LANES-1:0]       lane_rdy = '1;
   logic [NUM_LANES-1:0]       lane_done = '0;
   logic [NUM_LANES-1:0]       lane_ok = '0;
   logic                       lane_abort;

   crack_sched #(.KEY_W(KEY_W), .NUM_LANES(NUM_LANES)) dut (
      .clk(clk), .rst(rst), .en(en), .rdy(rdy),
      .key_lo(key_lo), .key_hi(key_hi), .key(key), .key_valid(key_valid), .done(done),
      .lane_en(lane_en), .lane_key(lane_key), .lane_rdy(lane_rdy),
      .lane_done(lane_done), .lane_ok(lane_ok), .lane_abort(lane_abort)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {int lane; int key; int cyc;} disp_t;

   int     n_cmp = 0;
   int     n_err = 0;
   bit     ok_tab [int];
   int     lat_tab [int];
   disp_t  disp_log [$];
   int     abort_cnt = 0;
   int     en_after_done = 0;
   int     ok_cyc = -1;
   int     multi_ok = 0;

   logic [NUM_LANES-1:0] m_busy = '0;
   int                   m_key [NUM_LANES];
   int                   m_cnt [NUM_LANES];

   // Lane engines: start on lane_en, answer after a per-key latency.
   always @(negedge clk) begin : lane_model
      int n_ok;
      n_ok = 0;
      for (int i = 0; i < NUM_LANES; i++) begin
         lane_done[i] = 1'b0;
         lane_ok[i]   = 1'b0;
         if (rst || lane_abort) begin
            m_busy[i] = 1'b0;
            m_cnt[i]  = 0;
         end else if (lane_en[i]) begin
            m_busy[i] = 1'b1;
            m_key[i]  = int'(lane_key[i*KEY_W +: KEY_W]);
            m_cnt[i]  = lat_tab.exists(m_key[i]) ? lat_tab[m_key[i]] : DEF_LAT;
         end else if (m_busy[i]) begin
            m_cnt[i]--;
            if (m_cnt[i] <= 0) begin
               m_busy[i]    = 1'b0;
               lane_done[i] = 1'b1;
               if (ok_tab.exists(m_key[i])) begin
                  lane_ok[i] = 1'b1;
                  n_ok++;
               end
            end
         end
         lane_rdy[i] = !m_busy[i];
      end
      if (n_ok > 0) ok_cyc = cyc;
      if (n_ok > 1) multi_ok++;
   end

   always @(negedge clk) begin : monitor
      if (!rst) begin
         for (int i = 0; i < NUM_LANES; i++)
            if (lane_en[i]) disp_log.push_back('{i, int'(lane_key[i*KEY_W +: KEY_W]), cyc});
         if (lane_abort) abort_cnt++;
         if (done && (lane_en != '0)) en_after_done++;
      end
   end

   localparam logic [KEY_W*(NUM_LANES+1)+NUM_LANES+3:0] RESET_VEC =
      {1'b1, 1'b0, 1'b0, {KEY_W{1'b0}}, {NUM_LANES{1'b0}}, {(NUM_LANES*KEY_W){1'b0}}, 1'b0};

   task automatic start_search(input logic [KEY_W-1:0] lo, input logic [KEY_W-1:0] top);
      @(negedge clk);
      key_lo = lo;
      key_hi = top;
      en     = 1'b1;
      @(negedge clk);
      en     = 1'b0;
   endtask

   task automatic wait_done(input string name, input int limit, output int seen_cyc);
      seen_cyc = -1;
      for (int c = 0; c < limit && seen_cyc < 0; c++) begin
         if (done === 1'b1) seen_cyc = cyc;
         else @(negedge clk);
      end
      n_cmp++;
      if (seen_cyc < 0) begin
         n_err++;
         $display("FAIL %s_timeout: done=%b after %0d cycles, required 1", name, done, limit);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({rdy, key_valid, done, key, lane_en, lane_key, lane_abort} !== RESET_VEC) begin
         n_err++;
         $display("FAIL reset_values: got %h, required %h",
                  {rdy, key_valid, done, key, lane_en, lane_key, lane_abort}, RESET_VEC);
      end
   endtask

   task automatic test_find_small();
      int exp_q [$];
      int base, ab, ead, seen, idx;
      ok_tab.delete();
      lat_tab.delete();
      ok_tab[32'h12] = 1'b1;
      base = disp_log.size();
      ab   = abort_cnt;
      ead  = en_after_done;
      for (int k = 0; k <= 32'h12; k++) exp_q.push_back(k);
      start_search(24'h000000, 24'hFFFFFF);
      wait_done("find_small", 400, seen);
      n_cmp++;
      if (key !== 24'h000012) begin n_err++; $display("FAIL find_small_key: got %h, required 000012", key); end
      n_cmp++;
      if (key_valid !== 1'b1) begin n_err++; $display("FAIL find_small_valid: got %b, required 1", key_valid); end
      n_cmp++;
      if (rdy !== 1'b1) begin n_err++; $display("FAIL find_small_rdy: got %b, required 1", rdy); end
      repeat (6) @(negedge clk);
      n_cmp++;
      if (abort_cnt - ab !== 1) begin n_err++; $display("FAIL find_small_abort: got %0d pulses, required 1", abort_cnt - ab); end
      n_cmp++;
      if (en_after_done - ead !== 0) begin n_err++; $display("FAIL find_small_late_en: got %0d, required 0", en_after_done - ead); end
      idx = base;
      while (exp_q.size() > 0) begin
         int exp_k;
         exp_k = exp_q.pop_front();
         n_cmp++;
         if (idx >= disp_log.size()) begin
            n_err++;
            $display("FAIL find_small_order: dispatch of %h missing, got none", exp_k);
         end else if (disp_log[idx].key !== exp_k) begin
            n_err++;
            $display("FAIL find_small_order: got %h, required %h", disp_log[idx].key, exp_k);
         end
         idx++;
      end
   endtask

   task automatic test_exhaust();
      int exp_q [$];
      int base, seen;
      ok_tab.delete();
      lat_tab.delete();
      base = disp_log.size();
      for (int k = 5; k <= 9; k++) exp_q.push_back(k);
      start_search(24'd5, 24'd9);
      n_cmp++;
      if (rdy !== 1'b0) begin n_err++; $display("FAIL exhaust_busy_rdy: got %b, required 0", rdy); end
      wait_done("exhaust", 200, seen);
      n_cmp++;
      if (key_valid !== 1'b0) begin n_err++; $display("FAIL exhaust_valid: got %b, required 0", key_valid); end
      n_cmp++;
      if (key !== '0) begin n_err++; $display("FAIL exhaust_key: got %h, required 000000", key); end
      repeat (4) @(negedge clk);
      n_cmp++;
      if (disp_log.size() - base !== 5) begin
         n_err++;
         $display("FAIL exhaust_count: got %0d lane_en, required 5", disp_log.size() - base);
      end
      for (int j = 0; j < 5 && base + j < disp_log.size(); j++) begin
         int exp_k;
         exp_k = exp_q.pop_front();
         n_cmp++;
         if (disp_log[base+j].key !== exp_k) begin
            n_err++;
            $display("FAIL exhaust_order: got %h, required %h", disp_log[base+j].key, exp_k);
         end
      end
      if (disp_log.size() - base >= 2) begin
         n_cmp++;
         if (disp_log[base].lane !== 0 || disp_log[base+1].lane !== 1 ||
             disp_log[base+1].cyc - disp_log[base].cyc !== 1) begin
            n_err++;
            $display("FAIL back_to_back: got lanes %0d,%0d gap %0d, required lanes 0,1 gap 1",
                     disp_log[base].lane, disp_log[base+1].lane, disp_log[base+1].cyc - disp_log[base].cyc);
         end
      end
   endtask

   task automatic test_top_key();
      int base, seen, zeros;
      ok_tab.delete();
      lat_tab.delete();
      ok_tab[32'hFFFFFF] = 1'b1;
      base = disp_log.size();
      start_search(24'hFFFFFF, 24'hFFFFFF);
      wait_done("top_key", 100, seen);
      n_cmp++;
      if (key !== 24'hFFFFFF) begin n_err++; $display("FAIL top_key_key: got %h, required ffffff", key); end
      n_cmp++;
      if (key_valid !== 1'b1) begin n_err++; $display("FAIL top_key_valid: got %b, required 1", key_valid); end
      repeat (6) @(negedge clk);
      n_cmp++;
      if (disp_log.size() - base !== 1) begin
         n_err++;
         $display("FAIL top_key_count: got %0d dispatches, required 1", disp_log.size() - base);
      end
      zeros = 0;
      for (int j = base; j < disp_log.size(); j++) if (disp_log[j].key == 0) zeros++;
      n_cmp++;
      if (zeros !== 0) begin n_err++; $display("FAIL top_key_wrap: got %0d dispatches of key 0, required 0", zeros); end
   endtask

   task automatic test_empty_range();
      int base;
      ok_tab.delete();
      lat_tab.delete();
      base = disp_log.size();
      start_search(24'd10, 24'd3);
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b1) begin n_err++; $display("FAIL empty_done: got %b, required 1", done); end
      n_cmp++;
      if (key_valid !== 1'b0) begin n_err++; $display("FAIL empty_valid: got %b, required 0", key_valid); end
      repeat (4) @(negedge clk);
      n_cmp++;
      if (disp_log.size() - base !== 0) begin
         n_err++;
         $display("FAIL empty_dispatch: got %0d lane_en, required 0", disp_log.size() - base);
      end
   endtask

   task automatic test_tie();
      int base, seen, mo;
      ok_tab.delete();
      lat_tab.delete();
      // Lane 0 runs 5 then 7, lane 1 runs 6; latencies line up 6 and 7 exactly.
      lat_tab[5] = 1;
      lat_tab[6] = 5;
      lat_tab[7] = 3;
      ok_tab[6] = 1'b1;
      ok_tab[7] = 1'b1;
      base = disp_log.size();
      mo   = multi_ok;
      start_search(24'd5, 24'd9);
      wait_done("tie", 100, seen);
      n_cmp++;
      if (multi_ok - mo !== 1) begin n_err++; $display("FAIL tie_same_cycle: got %0d joint ok cycles, required 1", multi_ok - mo); end
      n_cmp++;
      if (key !== 24'd7) begin n_err++; $display("FAIL tie_key: got %h, required 000007", key); end
      n_cmp++;
      if (key_valid !== 1'b1) begin n_err++; $display("FAIL tie_valid: got %b, required 1", key_valid); end
      n_cmp++;
      if (disp_log.size() - base < 3 || disp_log[base+2].lane !== 0 || disp_log[base+2].key !== 7) begin
         n_err++;
         $display("FAIL tie_dispatch: got %0d dispatches, required key 7 on lane 0 third", disp_log.size() - base);
      end
   endtask

   task automatic test_mid_reset();
      int seen;
      ok_tab.delete();
      lat_tab.delete();
      start_search(24'h000000, 24'hFFFFFF);
      repeat (15) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({rdy, key_valid, done, key, lane_en, lane_key, lane_abort} !== RESET_VEC) begin
         n_err++;
         $display("FAIL mid_reset_values: got %h, required %h",
                  {rdy, key_valid, done, key, lane_en, lane_key, lane_abort}, RESET_VEC);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      ok_tab[32'h12] = 1'b1;
      start_search(24'h000000, 24'h000020);
      wait_done("mid_reset", 400, seen);
      n_cmp++;
      if (key !== 24'h000012) begin n_err++; $display("FAIL mid_reset_key: got %h, required 000012", key); end
      n_cmp++;
      if (key_valid !== 1'b1) begin n_err++; $display("FAIL mid_reset_valid: got %b, required 1", key_valid); end
      n_cmp++;
      if (seen !== ok_cyc + 1) begin
         n_err++;
         $display("FAIL mid_reset_latency: got valid at cycle %0d, required %0d", seen, ok_cyc + 1);
      end
   endtask

   initial begin
      test_reset();
      test_find_small();
      test_exhaust();
      test_top_key();
      test_empty_range();
      test_tie();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
